wb_slave_mem: RTL and testbench
===============================

Name: wb_slave_mem

Overview:
- Wishbone B3 slave memory model, downstream of the Ethernet MAC DMA master port.
- Services buffer-descriptor fetches and frame data reads/writes issued by the MAC.
- Paired with the register-side master driver, it closes the loop for TX/RX DMA tests.
- Supports programmable wait states, byte-lane writes, incrementing bursts, error response on out-of-range addresses, and access counters for scoreboard checks.

Parameters:
- AW, 32: address width.
- DW, 32: data width; fixed at 32, with 4 byte lanes.
- MEM_DEPTH, 1024: memory size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- wb_clk_i, in, 1: Wishbone clock; the only clock.
- wb_rst_n_i, in, 1: reset, asynchronous assert, active-low.
- wb_adr_i, in, AW: byte address.
- wb_dat_i, in, DW: write data.
- wb_sel_i, in, 4: byte-lane enables.
- wb_we_i, in, 1: 1 = write, 0 = read.
- wb_cyc_i, in, 1: bus cycle valid.
- wb_stb_i, in, 1: strobe.
- wb_cti_i, in, 3: cycle type; 000 classic, 010 incrementing burst, 111 end-of-burst.
- wb_dat_o, out, DW: read data.
- wb_ack_o, out, 1: normal termination.
- wb_err_o, out, 1: error termination.
- wait_cfg_i, in, 4: wait states inserted before the first beat of each access.
- wr_cnt_o, out, 16: acked write beats; saturating.
- rd_cnt_o, out, 16: acked read beats; saturating.
- err_cnt_o, out, 16: error terminations; saturating.

Behaviour:
- Reset: wb_rst_n_i low asynchronously forces the FSM to IDLE. wb_ack_o, wb_err_o, wb_dat_o and all counters go to 0. Memory contents are not reset.
- Address decode:
  - idx = (wb_adr_i - BASE_ADDR) >> 2; wb_adr_i[1:0] is ignored.
  - The address is in range iff wb_adr_i >= BASE_ADDR and idx < MEM_DEPTH.
- FSM states: IDLE, WAIT, BEAT, BURST.
- IDLE:
  - Request = wb_cyc_i & wb_stb_i sampled at a clock edge.
  - wait_cfg_i is latched into the wait counter at that edge.
  - Counter > 0 → WAIT; counter = 0 → BEAT.
- WAIT: decrement the counter each edge; go to BEAT when it reaches 0.
- Latency: wb_ack_o/wb_err_o rises exactly wait_cfg_i+1 edges after the request edge.
- BEAT (first beat):
  - Assert wb_ack_o for one cycle if in range, else wb_err_o for one cycle. Never both.
  - Writes commit at the edge that sets ack: each byte lane with wb_sel_i[n]=1 updates mem[idx][8n+7:8n].
  - Reads: wb_dat_o = mem[idx] while ack is high; 0 at all other times.
  - An erroring write does not modify memory. An erroring read returns 0.
  - Next state: if wb_cti_i==010 and no error → BURST; else → IDLE.
- BURST:
  - One ack per cycle, zero wait states, at the current wb_adr_i.
  - The master increments the address; the slave decodes every beat independently.
  - A beat with wb_cti_i==111 is acked, then the FSM returns to IDLE.
  - An out-of-range beat gives wb_err_o and a return to IDLE.
- Back-to-back classic: after ack, the FSM passes through IDLE. A still-asserted stb with new address and data starts a new access on the next edge. Minimum classic spacing is 2 cycles at wait_cfg_i=0.
- Abort: wb_cyc_i or wb_stb_i low in WAIT, BEAT or BURST → IDLE next edge. No ack, no memory write, no counter change.
- Counters:
  - Increment on the edge that asserts the corresponding termination: write ack → wr_cnt_o, read ack → rd_cnt_o, any err → err_cnt_o.
  - Each saturates at 16'hFFFF.
- wait_cfg_i changes take effect only at the next IDLE request sample.
- wb_we_i, wb_sel_i and wb_dat_i are sampled on the beat edge, not the request edge.

Test Plan:
1. Reset, wait_cfg_i=0: write 32'hDEAD_BEEF to 0x10 with sel=1111, then read 0x10 → write ack 1 cycle after request; read returns 32'hDEAD_BEEF with ack; wr_cnt_o=1, rd_cnt_o=1.
2. Byte lanes: preload 0x20 with 32'h1122_3344, write 32'hAABB_CCDD with sel=0101, read back → 32'h11BB_33DD.
3. wait_cfg_i=3, single read → ack rises exactly 4 edges after the request edge. Repeat with cyc dropped during WAIT → no ack; counters unchanged.
4. Incrementing burst of 4 writes from 0x100, last beat cti=111, wait_cfg_i=2 → first ack after 3 edges, then 3 consecutive single-cycle acks. Readback of 0x100–0x10C matches; wr_cnt_o=4.
5. Access at BASE_ADDR + 4*MEM_DEPTH → wb_err_o for 1 cycle, no ack, memory unchanged, err_cnt_o=1. Burst crossing the top word → err on the first out-of-range beat, FSM returns to IDLE.
6. Assert wb_rst_n_i low mid-WAIT (asynchronously, between edges) → ack, err, dat_o and counters go to 0 immediately; the next request after release behaves normally.

Source files
------------

// File: rtl/wb_slave_mem.sv
// Wishbone B3 slave memory: programmable wait states, byte-lane writes, incrementing
// bursts, error termination outside the mapped window, saturating access counters.
module wb_slave_mem #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            MEM_DEPTH = 1024,
  parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  input  logic [3:0]    wait_cfg_i,
  output logic [15:0]   wr_cnt_o,
  output logic [15:0]   rd_cnt_o,
  output logic [15:0]   err_cnt_o
);
  localparam int         IW       = $clog2(MEM_DEPTH);
  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BEAT  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic [DW-1:0] mem [MEM_DEPTH];

  logic [AW-1:0] off_s;
  logic [IW-1:0] idx_s;
  logic          in_range_s;
  logic          req_s;
  logic          mem_we_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Offset is taken before the shift so addresses below the window wrap high and fail the check.
  assign off_s      = wb_adr_i - BASE_ADDR;
  assign idx_s      = off_s[IW+1:2];
  assign in_range_s = (wb_adr_i >= BASE_ADDR) && ((off_s >> 2) < AW'(MEM_DEPTH));
  assign req_s      = wb_cyc_i & wb_stb_i;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = '0;
    mem_we_s  = 1'b0;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          wcnt_d  = wait_cfg_i;
          state_d = (wait_cfg_i == 4'd0) ? S_BEAT : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else if (wcnt_q <= 4'd1) begin
          wcnt_d  = 4'd0;
          state_d = S_BEAT;
        end else begin
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      // First beat and burst beats terminate identically; only cti decides whether to continue.
      S_BEAT, S_BURST: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else if (in_range_s) begin
          ack_d = 1'b1;
          if (wb_we_i) begin
            mem_we_s = 1'b1;
            wr_cnt_d = sat_inc(wr_cnt_q);
          end else begin
            dat_d    = mem[idx_s];
            rd_cnt_d = sat_inc(rd_cnt_q);
          end
          state_d = (wb_cti_i == CTI_INCR) ? S_BURST : S_IDLE;
        end else begin
          err_d     = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, response and counter registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      wr_cnt_q  <= 16'd0;
      rd_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive a bus reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we_s) begin
      for (int n = 0; n < 4; n++) begin
        if (wb_sel_i[n]) begin
          mem[idx_s][8*n +: 8] <= wb_dat_i[8*n +: 8];
        end
      end
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign rd_cnt_o  = rd_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: directed scenarios plus randomized classic
// accesses, all checked against a word-array reference model of the memory map.
module tb_wb_slave_mem;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel, wait_cfg;
  logic        we, cyc, stb, ack, err;
  logic [2:0]  cti;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;

  always #5 clk = ~clk;

  wb_slave_mem #(.AW(32), .DW(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wait_cfg_i(wait_cfg),
    .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt), .err_cnt_o(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus termination counts.
  logic [31:0] ref_mem [DEPTH];
  int m_wr, m_rd, m_err;

  int          lat;
  bit          ga, ge, ea, ee;
  logic [31:0] gd, er;

  function automatic bit ref_in_range(input logic [31:0] a);
    longint la, lb;
    la = {32'd0, a};
    lb = {32'd0, BASE};
    return (la >= lb) && (((la - lb) / 4) < DEPTH);
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    longint la, lb;
    la = {32'd0, a};
    lb = {32'd0, BASE};
    return int'((la - lb) / 4);
  endfunction

  task automatic ref_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output bit oa, output bit oe,
                            output logic [31:0] od);
    int i;
    oa = 1'b0; oe = 1'b0; od = 32'd0;
    if (ref_in_range(a)) begin
      oa = 1'b1;
      i  = ref_idx(a);
      if (w) begin
        for (int n = 0; n < 4; n++) if (s[n]) ref_mem[i][8*n +: 8] = d[8*n +: 8];
        m_wr++;
      end else begin
        od = ref_mem[i];
        m_rd++;
      end
    end else begin
      oe = 1'b1;
      m_err++;
    end
  endtask

  // Presents a request and waits (bounded) for termination; bus is left driven.
  task automatic bus_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, output int l,
                         output bit oa, output bit oe, output logic [31:0] od);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; cti = c;
    l = -1; oa = 1'b0; oe = 1'b0; od = 32'd0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        l = n; oa = ack; oe = err; od = rdat;
        break;
      end
    end
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    adr = 32'd0; wdat = 32'd0; sel = 4'h0; wait_cfg = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, err, rdat} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {ack, err, rdat});
    end
    checks++;
    if ({wr_cnt, rd_cnt, err_cnt} !== 48'd0) begin
      errors++; $display("FAIL reset_counters got %h exp 0", {wr_cnt, rd_cnt, err_cnt});
    end
    rst_n = 1'b1;
    m_wr = 0; m_rd = 0; m_err = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wait_cfg = 4'd0;
    ref_access(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, ea, ee, er);
    bus_req(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL basic_wr_latency got %0d exp 1", lat); end
    checks++;
    if ({ga, ge, gd} !== {ea, ee, er}) begin
      errors++; $display("FAIL basic_wr_resp got %h exp %h", {ga, ge, gd}, {ea, ee, er});
    end
    bus_idle();
    checks++;
    if ({ack, err} !== 2'b00) begin errors++; $display("FAIL basic_ack_single got %b exp 00", {ack, err}); end
    ref_access(1'b0, BASE + 32'h10, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE + 32'h10, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (gd !== 32'hDEAD_BEEF || !ga || ge || lat !== 1) begin
      errors++; $display("FAIL basic_rd got dat=%h ack=%b err=%b lat=%0d exp DEADBEEF 1 0 1", gd, ga, ge, lat);
    end
    bus_idle();
    checks++;
    if (rdat !== 32'd0) begin errors++; $display("FAIL basic_dat_idle got %h exp 0", rdat); end
    checks++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
      errors++; $display("FAIL basic_counters got wr=%0d rd=%0d exp 1 1", wr_cnt, rd_cnt);
    end
  endtask

  // Fills every word with back-to-back writes (stb held), then back-to-back random reads.
  task automatic test_back_to_back();
    logic [31:0] d, a;
    wait_cfg = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      a = BASE + 32'(4 * i);
      ref_access(1'b1, a, d, 4'hF, ea, ee, er);
      bus_req(1'b1, a, d, 4'hF, 3'b000, lat, ga, ge, gd);
      checks++;
      if (lat !== 1 || !ga || ge) begin
        errors++; $display("FAIL b2b_wr idx=%0d got lat=%0d ack=%b err=%b exp 1 1 0", i, lat, ga, ge);
      end
    end
    for (int i = 0; i < 16; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      ref_access(1'b0, a, 32'd0, 4'hF, ea, ee, er);
      bus_req(1'b0, a, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
      checks++;
      if (lat !== 1 || {ga, ge, gd} !== {ea, ee, er}) begin
        errors++; $display("FAIL b2b_rd adr=%h got lat=%0d %h exp 1 %h", a, lat, {ga, ge, gd}, {ea, ee, er});
      end
    end
    bus_idle();
    checks++;
    if (wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd)) begin
      errors++; $display("FAIL b2b_counters got wr=%0d rd=%0d exp %0d %0d", wr_cnt, rd_cnt, m_wr, m_rd);
    end
  endtask

  task automatic test_byte_lanes();
    wait_cfg = 4'd0;
    ref_access(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, ea, ee, er);
    bus_req(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 3'b000, lat, ga, ge, gd);
    bus_idle();
    ref_access(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, ea, ee, er);
    bus_req(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 3'b000, lat, ga, ge, gd);
    bus_idle();
    ref_access(1'b0, BASE + 32'h20, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE + 32'h20, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (gd !== 32'h11BB_33DD || er !== 32'h11BB_33DD) begin
      errors++; $display("FAIL byte_lanes got %h exp 11bb33dd", gd);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    bit seen;
    int n;
    wait_cfg = 4'd3;
    ref_access(1'b0, BASE + 32'h14, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE + 32'h14, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (lat !== 4 || {ga, ge, gd} !== {ea, ee, er}) begin
      errors++; $display("FAIL wait3_rd got lat=%0d %h exp 4 %h", lat, {ga, ge, gd}, {ea, ee, er});
    end
    bus_idle();
    // wait_cfg change after the request edge must not shorten the access
    ref_access(1'b0, BASE + 32'h18, 32'd0, 4'hF, ea, ee, er);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h18; cti = 3'b000;
    @(posedge clk); #1;
    wait_cfg = 4'd0;
    n = -1;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
      if (ack || err) begin n = k; break; end
    end
    checks++;
    if (n !== 4 || rdat !== er) begin
      errors++; $display("FAIL wait_cfg_latched got lat=%0d dat=%h exp 4 %h", n, rdat, er);
    end
    bus_idle();
    // abort in WAIT: write never commits
    wait_cfg = 4'd3;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h1C; wdat = ~ref_mem[7]; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack || err) seen = 1'b1;
    end
    bus_idle();
    checks++;
    if (seen) begin errors++; $display("FAIL abort_wait got termination exp none"); end
    // abort in BEAT: stb drops after the request edge
    wait_cfg = 4'd0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h1C; wdat = ~ref_mem[7]; sel = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack || err) seen = 1'b1;
    end
    bus_idle();
    checks++;
    if (seen) begin errors++; $display("FAIL abort_beat got termination exp none"); end
    checks++;
    if (wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd) || err_cnt !== 16'(m_err)) begin
      errors++; $display("FAIL abort_counters got %0d %0d %0d exp %0d %0d %0d", wr_cnt, rd_cnt, err_cnt, m_wr, m_rd, m_err);
    end
    ref_access(1'b0, BASE + 32'h1C, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE + 32'h1C, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (gd !== er) begin errors++; $display("FAIL abort_mem_unchanged got %h exp %h", gd, er); end
    bus_idle();
  endtask

  task automatic test_burst();
    logic [31:0] a0, d;
    a0 = BASE + 32'h100;
    wait_cfg = 4'd2;
    d = $urandom;
    ref_access(1'b1, a0, d, 4'hF, ea, ee, er);
    bus_req(1'b1, a0, d, 4'hF, 3'b010, lat, ga, ge, gd);
    checks++;
    if (lat !== 3 || !ga || ge) begin
      errors++; $display("FAIL burst_first got lat=%0d ack=%b err=%b exp 3 1 0", lat, ga, ge);
    end
    for (int k = 1; k < 4; k++) begin
      d = $urandom;
      ref_access(1'b1, a0 + 32'(4 * k), d, 4'hF, ea, ee, er);
      adr = a0 + 32'(4 * k); wdat = d; cti = (k == 3) ? 3'b111 : 3'b010;
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL burst_wr_beat%0d got ack=%b err=%b exp 1 0", k, ack, err);
      end
    end
    // stb held after end-of-burst: a classic read must take the full IDLE path
    wait_cfg = 4'd0;
    ref_access(1'b0, a0, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, a0, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (lat !== 1 || gd !== er) begin
      errors++; $display("FAIL burst_end_idle got lat=%0d dat=%h exp 1 %h", lat, gd, er);
    end
    bus_idle();
    ref_access(1'b0, a0, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, a0, 32'd0, 4'hF, 3'b010, lat, ga, ge, gd);
    checks++;
    if (lat !== 1 || gd !== er) begin
      errors++; $display("FAIL burst_rd_beat0 got lat=%0d dat=%h exp 1 %h", lat, gd, er);
    end
    for (int k = 1; k < 4; k++) begin
      ref_access(1'b0, a0 + 32'(4 * k), 32'd0, 4'hF, ea, ee, er);
      adr = a0 + 32'(4 * k); cti = (k == 3) ? 3'b111 : 3'b010;
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b1 || rdat !== er) begin
        errors++; $display("FAIL burst_rd_beat%0d got ack=%b dat=%h exp 1 %h", k, ack, rdat, er);
      end
    end
    bus_idle();
    checks++;
    if (wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd)) begin
      errors++; $display("FAIL burst_counters got wr=%0d rd=%0d exp %0d %0d", wr_cnt, rd_cnt, m_wr, m_rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] top, a0;
    top = BASE + 32'(4 * DEPTH);
    wait_cfg = 4'd0;
    ref_access(1'b1, top, 32'hCAFE_F00D, 4'hF, ea, ee, er);
    bus_req(1'b1, top, 32'hCAFE_F00D, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (lat !== 1 || ga || !ge) begin
      errors++; $display("FAIL err_top_wr got lat=%0d ack=%b err=%b exp 1 0 1", lat, ga, ge);
    end
    bus_idle();
    checks++;
    if ({ack, err} !== 2'b00) begin errors++; $display("FAIL err_single got %b exp 00", {ack, err}); end
    checks++;
    if (err_cnt !== 16'd1) begin errors++; $display("FAIL err_cnt_first got %0d exp 1", err_cnt); end
    ref_access(1'b0, BASE - 32'd4, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE - 32'd4, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if ({ga, ge, gd} !== {ea, ee, er}) begin
      errors++; $display("FAIL err_below_rd got %h exp %h", {ga, ge, gd}, {ea, ee, er});
    end
    bus_idle();
    ref_access(1'b0, BASE, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (gd !== er) begin errors++; $display("FAIL err_mem_unchanged got %h exp %h", gd, er); end
    bus_idle();
    // burst walking off the top word
    a0 = BASE + 32'(4 * (DEPTH - 2));
    ref_access(1'b1, a0, 32'h0101_0101, 4'hF, ea, ee, er);
    bus_req(1'b1, a0, 32'h0101_0101, 4'hF, 3'b010, lat, ga, ge, gd);
    ref_access(1'b1, a0 + 32'd4, 32'h0202_0202, 4'hF, ea, ee, er);
    adr = a0 + 32'd4; wdat = 32'h0202_0202;
    @(posedge clk); #1;
    checks++;
    if ({ga, ack, err} !== 3'b110) begin
      errors++; $display("FAIL err_burst_inrange got %b exp 110", {ga, ack, err});
    end
    ref_access(1'b1, top, 32'h0303_0303, 4'hF, ea, ee, er);
    adr = top; wdat = 32'h0303_0303;
    @(posedge clk); #1;
    checks++;
    if ({ack, err} !== 2'b01) begin
      errors++; $display("FAIL err_burst_cross got ack/err=%b exp 01", {ack, err});
    end
    ref_access(1'b0, BASE + 32'd8, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, BASE + 32'd8, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (lat !== 1 || gd !== er) begin
      errors++; $display("FAIL err_burst_to_idle got lat=%0d dat=%h exp 1 %h", lat, gd, er);
    end
    bus_idle();
    checks++;
    if (err_cnt !== 16'(m_err) || wr_cnt !== 16'(m_wr)) begin
      errors++; $display("FAIL err_counters got err=%0d wr=%0d exp %0d %0d", err_cnt, wr_cnt, m_err, m_wr);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          w;
    int          r, wc;
    for (int i = 0; i < 80; i++) begin
      wc = $urandom_range(0, 3);
      wait_cfg = 4'(wc);
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
      else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 64));
      else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      ref_access(w, a, d, s, ea, ee, er);
      bus_req(w, a, d, s, 3'b000, lat, ga, ge, gd);
      checks++;
      if (lat !== wc + 1 || {ga, ge, gd} !== {ea, ee, er}) begin
        errors++; $display("FAIL rand%0d adr=%h we=%b got lat=%0d %h exp %0d %h", i, a, w, lat, {ga, ge, gd}, wc + 1, {ea, ee, er});
      end
      if ($urandom_range(0, 1) == 1) bus_idle();
    end
    bus_idle();
    checks++;
    if (wr_cnt !== 16'(m_wr) || rd_cnt !== 16'(m_rd) || err_cnt !== 16'(m_err)) begin
      errors++; $display("FAIL rand_counters got %0d %0d %0d exp %0d %0d %0d", wr_cnt, rd_cnt, err_cnt, m_wr, m_rd, m_err);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    wait_cfg = 4'd5;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h40; cti = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, err, rdat, wr_cnt, rd_cnt, err_cnt} !== 82'd0) begin
      errors++; $display("FAIL async_reset got ack=%b err=%b dat=%h cnt=%0d/%0d/%0d exp all 0", ack, err, rdat, wr_cnt, rd_cnt, err_cnt);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    m_wr = 0; m_rd = 0; m_err = 0;
    @(posedge clk); #1;
    wait_cfg = 4'd0;
    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    ref_access(1'b0, a, 32'd0, 4'hF, ea, ee, er);
    bus_req(1'b0, a, 32'd0, 4'hF, 3'b000, lat, ga, ge, gd);
    checks++;
    if (lat !== 1 || {ga, ge, gd} !== {ea, ee, er}) begin
      errors++; $display("FAIL post_reset_rd got lat=%0d %h exp 1 %h", lat, {ga, ge, gd}, {ea, ee, er});
    end
    bus_idle();
    checks++;
    if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
      errors++; $display("FAIL post_reset_cnt got rd=%0d wr=%0d exp 1 0", rd_cnt, wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_burst();
    test_errors();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
